// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and helpers.
// Shared by the sync generator and its pixel-rate divider.
package vga_timing_pkg;

  localparam int CNT_W     = 10;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT
                           + H_SYNC + H_BACK;

  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT
                           + V_SYNC + V_BACK;

  localparam int PIX_DIV   = 4;

  typedef logic [CNT_W-1:0] coord_t;

  // Closed-interval membership, used for the sync windows.
  function automatic logic in_window(
    input coord_t c,
    input coord_t lo,
    input coord_t hi
  );
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle from the sync generator to the
// pixel/graphics generator.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic   p_tick;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  coord_t pixel_x;
  coord_t pixel_y;
  logic   frame_tick;

  modport master (
    output p_tick,
    output hsync,
    output vsync,
    output video_on,
    output pixel_x,
    output pixel_y,
    output frame_tick
  );

  modport slave (
    input p_tick,
    input hsync,
    input vsync,
    input video_on,
    input pixel_x,
    input pixel_y,
    input frame_tick
  );

endinterface

// File: rtl/pixel_tick_gen.sv
// Mod-DIV clock divider producing a one-clk
// pixel strobe on the last count.
module pixel_tick_gen
  import vga_timing_pkg::*;
#(
  parameter int DIV = PIX_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Free-running divider, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: h/v raster counters, registered
// active-low syncs, visible-area flag and frame strobe.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int P_H_DISPLAY = H_DISPLAY,
  parameter int P_H_FRONT   = H_FRONT,
  parameter int P_H_SYNC    = H_SYNC,
  parameter int P_H_BACK    = H_BACK,
  parameter int P_V_DISPLAY = V_DISPLAY,
  parameter int P_V_FRONT   = V_FRONT,
  parameter int P_V_SYNC    = V_SYNC,
  parameter int P_V_BACK    = V_BACK,
  parameter int P_PIX_DIV   = PIX_DIV
) (
  input logic       clk,
  input logic       reset,
  vga_sync_gen_if.master vga
);

  localparam int HT = P_H_DISPLAY + P_H_FRONT
                    + P_H_SYNC + P_H_BACK;
  localparam int VT = P_V_DISPLAY + P_V_FRONT
                    + P_V_SYNC + P_V_BACK;

  localparam coord_t H_LAST = coord_t'(HT - 1);
  localparam coord_t V_LAST = coord_t'(VT - 1);
  localparam coord_t H_VIS  = coord_t'(P_H_DISPLAY);
  localparam coord_t V_VIS  = coord_t'(P_V_DISPLAY);

  localparam coord_t HS_LO =
    coord_t'(P_H_DISPLAY + P_H_FRONT);
  localparam coord_t HS_HI =
    coord_t'(P_H_DISPLAY + P_H_FRONT + P_H_SYNC - 1);
  localparam coord_t VS_LO =
    coord_t'(P_V_DISPLAY + P_V_FRONT);
  localparam coord_t VS_HI =
    coord_t'(P_V_DISPLAY + P_V_FRONT + P_V_SYNC - 1);

  logic   p_tick;
  coord_t h_q;
  coord_t v_q;
  coord_t h_d;
  coord_t v_d;
  logic   h_end;
  logic   v_end;
  logic   hsync_q;
  logic   vsync_q;

  pixel_tick_gen #(
    .DIV (P_PIX_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (p_tick)
  );

  // Next raster position; h wrap and v step share one edge.
  always_comb begin
    h_end = (h_q >= H_LAST);
    v_end = (v_q >= V_LAST);
    h_d   = h_q;
    v_d   = v_q;
    if (p_tick) begin
      h_d = h_end ? '0 : h_q + 1'b1;
      if (h_end) begin
        v_d = v_end ? '0 : v_q + 1'b1;
      end else if (v_q > V_LAST) begin
        v_d = '0;
      end
    end
  end

  // Counters and syncs; syncs are decoded from the next
  // position so they line up with pixel_x/pixel_y.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= ~in_window(h_d, HS_LO, HS_HI);
      vsync_q <= ~in_window(v_d, VS_LO, VS_HI);
    end
  end

  assign vga.p_tick     = p_tick;
  assign vga.pixel_x    = h_q;
  assign vga.pixel_y    = v_q;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.video_on   = (h_q < H_VIS) && (v_q < V_VIS);
  assign vga.frame_tick = p_tick && (h_q == H_LAST)
                        && (v_q == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size instance for line timing,
// reduced-raster instance for frame-level behaviour.
module tb_vga_sync_gen;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   total;
  int   bad;
  int   cyc;

  vga_sync_gen_if ia ();
  vga_sync_gen_if ib ();

  // Full 640x480 timing.
  vga_sync_gen dut_a (
    .clk   (clk),
    .reset (rst_a),
    .vga   (ia)
  );

  // Small raster: h 8+2+3+3=16, v 4+1+2+1=8.
  // hsync low x 10..12, vsync low y 5..6, frame 512 clks.
  vga_sync_gen #(
    .P_H_DISPLAY (8),
    .P_H_FRONT   (2),
    .P_H_SYNC    (3),
    .P_H_BACK    (3),
    .P_V_DISPLAY (4),
    .P_V_FRONT   (1),
    .P_V_SYNC    (2),
    .P_V_BACK    (1),
    .P_PIX_DIV   (4)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .vga   (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int cx(input bit sel);
    return sel ? int'(ib.pixel_x) : int'(ia.pixel_x);
  endfunction

  function automatic int cy(input bit sel);
    return sel ? int'(ib.pixel_y) : int'(ia.pixel_y);
  endfunction

  function automatic logic ct(input bit sel);
    return sel ? ib.p_tick : ia.p_tick;
  endfunction

  // Bounded wait for a raster position (y<0: any line).
  task automatic wait_xy(
    input bit sel, input int x, input int y,
    input bit need_tick, input int limit
  );
    bit ok;
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      if (cx(sel) == x && (y < 0 || cy(sel) == y)
          && (!need_tick || ct(sel) === 1'b1)) begin
        ok = 1;
        break;
      end
      step();
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_xy sel=%0d got (%0d,%0d) want (%0d,%0d)",
               sel, cx(sel), cy(sel), x, y);
    end
  endtask

  task automatic test_reset;
    rst_a = 1'b1;
    rst_b = 1'b1;
    step();
    step();
    total += 9;
    if (ia.p_tick !== 1'b0) begin
      bad++; $display("FAIL rst_ptick got %b want 0", ia.p_tick);
    end
    if (ia.pixel_x !== 10'd0) begin
      bad++; $display("FAIL rst_x got %0d want 0", ia.pixel_x);
    end
    if (ia.pixel_y !== 10'd0) begin
      bad++; $display("FAIL rst_y got %0d want 0", ia.pixel_y);
    end
    if (ia.hsync !== 1'b1) begin
      bad++; $display("FAIL rst_hsync got %b want 1", ia.hsync);
    end
    if (ia.vsync !== 1'b1) begin
      bad++; $display("FAIL rst_vsync got %b want 1", ia.vsync);
    end
    if (ia.video_on !== 1'b1) begin
      bad++; $display("FAIL rst_video got %b want 1", ia.video_on);
    end
    if (ia.frame_tick !== 1'b0) begin
      bad++; $display("FAIL rst_ftick got %b want 0", ia.frame_tick);
    end
    if (ib.hsync !== 1'b1 || ib.vsync !== 1'b1) begin
      bad++; $display("FAIL rst_b_sync got %b%b want 11",
                      ib.hsync, ib.vsync);
    end
    if (ib.pixel_x !== 10'd0 || ib.pixel_y !== 10'd0) begin
      bad++; $display("FAIL rst_b_xy got (%0d,%0d) want (0,0)",
                      ib.pixel_x, ib.pixel_y);
    end
  endtask

  task automatic test_first_tick;
    logic exp_t;
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_t = ((k % 4) == 3);
      total += 3;
      if (ia.p_tick !== exp_t) begin
        bad++; $display("FAIL tick_k%0d got %b want %b",
                        k, ia.p_tick, exp_t);
      end
      if (int'(ia.pixel_x) != k / 4) begin
        bad++; $display("FAIL tick_x_k%0d got %0d want %0d",
                        k, ia.pixel_x, k / 4);
      end
      if (ia.pixel_y !== 10'd0) begin
        bad++; $display("FAIL tick_y_k%0d got %0d want 0",
                        k, ia.pixel_y);
      end
    end
  endtask

  task automatic test_visible_a;
    wait_xy(0, 639, 0, 0, 4000);
    total++;
    if (ia.video_on !== 1'b1) begin
      bad++; $display("FAIL vis_639 got %b want 1", ia.video_on);
    end
    wait_xy(0, 640, 0, 0, 16);
    total++;
    if (ia.video_on !== 1'b0) begin
      bad++; $display("FAIL vis_640 got %b want 0", ia.video_on);
    end
  endtask

  task automatic test_hsync_a;
    int n;
    wait_xy(0, 655, -1, 0, 4000);
    total++;
    if (ia.hsync !== 1'b1) begin
      bad++; $display("FAIL hs_655 got %b want 1", ia.hsync);
    end
    for (int i = 0; i < 8 && ia.pixel_x == 10'd655; i++) step();
    total += 2;
    if (ia.pixel_x !== 10'd656) begin
      bad++; $display("FAIL hs_start_x got %0d want 656", ia.pixel_x);
    end
    if (ia.hsync !== 1'b0) begin
      bad++; $display("FAIL hs_656 got %b want 0", ia.hsync);
    end
    n = 1;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (ia.hsync !== 1'b0) break;
      n++;
    end
    total += 2;
    if (n != 384) begin
      bad++; $display("FAIL hs_width got %0d want 384", n);
    end
    if (ia.pixel_x !== 10'd752) begin
      bad++; $display("FAIL hs_end_x got %0d want 752", ia.pixel_x);
    end
  endtask

  task automatic test_line_a;
    int t0;
    int t1;
    wait_xy(0, 799, 0, 1, 4000);
    step();
    t0 = cyc;
    total++;
    if (ia.pixel_x !== 10'd0 || ia.pixel_y !== 10'd1) begin
      bad++; $display("FAIL line_wrap got (%0d,%0d) want (0,1)",
                      ia.pixel_x, ia.pixel_y);
    end
    wait_xy(0, 799, 1, 1, 4000);
    step();
    t1 = cyc;
    total += 2;
    if (t1 - t0 != 3200) begin
      bad++; $display("FAIL line_period got %0d want 3200", t1 - t0);
    end
    if (ia.pixel_x !== 10'd0 || ia.pixel_y !== 10'd2) begin
      bad++; $display("FAIL line_wrap2 got (%0d,%0d) want (0,2)",
                      ia.pixel_x, ia.pixel_y);
    end
  endtask

  task automatic test_mid_reset_a;
    wait_xy(0, 700, -1, 0, 4000);
    total++;
    if (ia.hsync !== 1'b0) begin
      bad++; $display("FAIL mra_pre_hs got %b want 0", ia.hsync);
    end
    rst_a = 1'b1;
    step();
    total++;
    if (ia.pixel_x !== 10'd0 || ia.pixel_y !== 10'd0 ||
        ia.hsync !== 1'b1 || ia.vsync !== 1'b1 ||
        ia.frame_tick !== 1'b0 || ia.p_tick !== 1'b0) begin
      bad++; $display("FAIL mra_state got x=%0d y=%0d hs=%b vs=%b ft=%b pt=%b want 0 0 1 1 0 0",
                      ia.pixel_x, ia.pixel_y, ia.hsync,
                      ia.vsync, ia.frame_tick, ia.p_tick);
    end
    rst_a = 1'b0;
    step();
    step();
    total++;
    if (ia.p_tick !== 1'b0) begin
      bad++; $display("FAIL mra_tick2 got %b want 0", ia.p_tick);
    end
    step();
    total++;
    if (ia.p_tick !== 1'b1) begin
      bad++; $display("FAIL mra_tick3 got %b want 1", ia.p_tick);
    end
    step();
    total++;
    if (ia.pixel_x !== 10'd1) begin
      bad++; $display("FAIL mra_x got %0d want 1", ia.pixel_x);
    end
  endtask

  task automatic test_wrap_b;
    wait_xy(1, 15, 6, 1, 1200);
    total++;
    if (ib.frame_tick !== 1'b0) begin
      bad++; $display("FAIL wrap_ft6 got %b want 0", ib.frame_tick);
    end
    step();
    total++;
    if (ib.pixel_x !== 10'd0 || ib.pixel_y !== 10'd7) begin
      bad++; $display("FAIL wrap_line got (%0d,%0d) want (0,7)",
                      ib.pixel_x, ib.pixel_y);
    end
    wait_xy(1, 15, 7, 1, 1200);
    total++;
    if (ib.frame_tick !== 1'b1) begin
      bad++; $display("FAIL wrap_ft7 got %b want 1", ib.frame_tick);
    end
    step();
    total += 2;
    if (ib.pixel_x !== 10'd0 || ib.pixel_y !== 10'd0) begin
      bad++; $display("FAIL wrap_frame got (%0d,%0d) want (0,0)",
                      ib.pixel_x, ib.pixel_y);
    end
    if (ib.frame_tick !== 1'b0) begin
      bad++; $display("FAIL wrap_ft_after got %b want 0",
                      ib.frame_tick);
    end
  endtask

  task automatic test_frame_b;
    int n;
    int pos;
    wait_xy(1, 15, 7, 1, 1200);
    n = 0;
    pos = 0;
    for (int i = 1; i <= 512; i++) begin
      step();
      if (ib.frame_tick === 1'b1) begin
        n++;
        pos = i;
      end
    end
    total += 2;
    if (n != 1) begin
      bad++; $display("FAIL frame_count got %0d want 1", n);
    end
    if (pos != 512) begin
      bad++; $display("FAIL frame_period got %0d want 512", pos);
    end
  endtask

  task automatic test_vsync_b;
    int n;
    wait_xy(1, 15, 4, 1, 1200);
    total++;
    if (ib.vsync !== 1'b1) begin
      bad++; $display("FAIL vs_pre got %b want 1", ib.vsync);
    end
    step();
    total += 2;
    if (ib.vsync !== 1'b0) begin
      bad++; $display("FAIL vs_start got %b want 0", ib.vsync);
    end
    if (ib.pixel_x !== 10'd0 || ib.pixel_y !== 10'd5) begin
      bad++; $display("FAIL vs_start_xy got (%0d,%0d) want (0,5)",
                      ib.pixel_x, ib.pixel_y);
    end
    n = 1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (ib.vsync !== 1'b0) break;
      n++;
    end
    total += 2;
    if (n != 128) begin
      bad++; $display("FAIL vs_width got %0d want 128", n);
    end
    if (ib.pixel_x !== 10'd0 || ib.pixel_y !== 10'd7) begin
      bad++; $display("FAIL vs_end_xy got (%0d,%0d) want (0,7)",
                      ib.pixel_x, ib.pixel_y);
    end
  endtask

  task automatic test_visible_b;
    int x;
    int y;
    logic ev;
    logic eh;
    wait_xy(1, 0, 0, 0, 1200);
    for (int i = 0; i < 512; i++) begin
      x = int'(ib.pixel_x);
      y = int'(ib.pixel_y);
      if (ib.p_tick === 1'b1) begin
        if ((x == 7 && y == 3) || (x == 8 && y == 0) ||
            (x == 0 && y == 4) || (x == 15 && y == 7) ||
            (x == 8 && y == 3) || (x == 7 && y == 4)) begin
          ev = (x == 7 && y == 3);
          total++;
          if (ib.video_on !== ev) begin
            bad++; $display("FAIL vis_b_%0d_%0d got %b want %b",
                            x, y, ib.video_on, ev);
          end
        end
        if (y == 0) begin
          eh = !(x >= 10 && x <= 12);
          total++;
          if (ib.hsync !== eh) begin
            bad++; $display("FAIL hs_b_x%0d got %b want %b",
                            x, ib.hsync, eh);
          end
        end
      end
      step();
    end
  endtask

  task automatic test_mid_reset_b;
    int n;
    wait_xy(1, 11, 5, 0, 1200);
    total++;
    if (ib.hsync !== 1'b0 || ib.vsync !== 1'b0) begin
      bad++; $display("FAIL mrb_pre got %b%b want 00",
                      ib.hsync, ib.vsync);
    end
    rst_b = 1'b1;
    step();
    total++;
    if (ib.pixel_x !== 10'd0 || ib.pixel_y !== 10'd0 ||
        ib.hsync !== 1'b1 || ib.vsync !== 1'b1 ||
        ib.frame_tick !== 1'b0 || ib.video_on !== 1'b1) begin
      bad++; $display("FAIL mrb_state got x=%0d y=%0d hs=%b vs=%b ft=%b vo=%b want 0 0 1 1 0 1",
                      ib.pixel_x, ib.pixel_y, ib.hsync,
                      ib.vsync, ib.frame_tick, ib.video_on);
    end
    rst_b = 1'b0;
    n = 0;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (ib.frame_tick === 1'b1) n++;
    end
    total += 2;
    if (ib.p_tick !== 1'b1) begin
      bad++; $display("FAIL mrb_tick3 got %b want 1", ib.p_tick);
    end
    if (n != 0) begin
      bad++; $display("FAIL mrb_ftick got %0d want 0", n);
    end
    step();
    total++;
    if (ib.pixel_x !== 10'd1 || ib.pixel_y !== 10'd0) begin
      bad++; $display("FAIL mrb_xy got (%0d,%0d) want (1,0)",
                      ib.pixel_x, ib.pixel_y);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    test_reset();
    test_first_tick();
    test_visible_a();
    test_hsync_a();
    test_line_a();
    test_mid_reset_a();
    test_wrap_b();
    test_frame_b();
    test_vsync_b();
    test_visible_b();
    test_mid_reset_b();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Port: clk  input  1  system clock, 100 MHz; the only clock; all state updates on its rising edge.
REQ-002 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 Port: p_tick  output  1  pixel-rate strobe, high for one clk every 4 clks (25 MHz).
REQ-004 Port: hsync  output  1  horizontal sync, active-low, registered.
REQ-005 Port: vsync  output  1  vertical sync, active-low, registered.
REQ-006 Port: video_on  output  1  high while (pixel_x, pixel_y) lies in the visible 640x480 area.
REQ-007 Port: pixel_x  output  10  current horizontal count, 0..799.
REQ-008 Port: pixel_y  output  10  current vertical count, 0..524.
REQ-009 Port: frame_tick  output  1  one-clk pulse at the last pixel of each frame.

Function
REQ-010 The block SHALL hold a 2-bit divider: 0->1->2->3->0, advancing every clk; p_tick = 1 exactly when the divider = 3.
REQ-011 The horizontal counter SHALL advance only on clks where p_tick = 1: 0..798 -> +1, 799 -> 0.
REQ-012 The vertical counter SHALL advance only on clks where p_tick = 1 and h = 799: 0..523 -> +1, 524 -> 0; otherwise it holds.
REQ-013 The block SHALL drive pixel_x and pixel_y directly from the registered counters, with zero added latency.
REQ-014 The block SHALL use horizontal timing of 640 display, 16 front porch, 96 sync and 48 back porch, for 800 total.
REQ-015 The block SHALL use vertical timing of 480 display, 10 front porch, 2 sync and 33 back porch, for 525 total.
REQ-016 hsync and vsync SHALL be registered from the next-state counter values, so that they align with pixel_x and pixel_y on the same clk.
REQ-017 hsync SHALL be 0 iff pixel_x is in 656..751.
REQ-018 vsync SHALL be 0 iff pixel_y is in 490..491.
REQ-019 video_on SHALL be combinational: 1 iff pixel_x < 640 and pixel_y < 480.
REQ-020 frame_tick SHALL be 1 iff p_tick = 1, pixel_x = 799 and pixel_y = 524; it is coincident with the wrap strobe.
REQ-021 The wrap at h = 799 and the v increment SHALL happen on the same clk edge. There is never an intermediate state such as x = 0 with y stale.
REQ-022 Arithmetic SHALL be unsigned 10-bit. Counters never exceed 799 / 524; any out-of-range value reached SHALL wrap to 0 on the next p_tick.

Reset
REQ-023 While reset = 1 at a clk edge, the block SHALL clear the divider, h and v to 0, and SHALL set hsync = 1, vsync = 1 and frame_tick = 0.
REQ-024 As a consequence of REQ-023, p_tick = 0 and video_on = 1 during and immediately after reset.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately, with no frame_tick and no sync pulse completion.
REQ-026 After reset deasserts, the first p_tick SHALL occur on the 4th clk (divider 0,1,2,3).

Structure
REQ-027 Package vga_timing_pkg SHALL hold all timing constants: H_DISPLAY, H_FRONT, H_SYNC, H_BACK, H_TOTAL, V_DISPLAY, V_FRONT, V_SYNC, V_BACK, V_TOTAL and PIX_DIV = 4.
REQ-028 No numeric timing literal SHALL appear in vga_sync_gen.
REQ-029 Sub-module pixel_tick_gen (mod-PIX_DIV counter, outputs tick) SHALL produce p_tick. The h/v counters and sync logic SHALL stay in vga_sync_gen.
REQ-030 The block's outputs SHALL feed the downstream pixel/graphics generator that produces rgb[11:0]. That generator qualifies its pixel updates with p_tick and blanks rgb when video_on = 0.

Verification
REQ-031 Reset, then release -> p_tick first high on clk 4, then every 4 clks; pixel_x = 1 after the first p_tick.
REQ-032 Run one line -> hsync low for exactly 384 clks (96 pixels), starting when pixel_x becomes 656; line period 3200 clks.
REQ-033 Run a full frame -> vsync low for exactly 6400 clks (2 lines) at pixel_y 490..491; frame_tick period 1,680,000 clks, with exactly one pulse per frame.
REQ-034 Check the visible boundary -> video_on = 1 at (639,479) and 0 at (640,y), (x,480) and (799,524).
REQ-035 Check the wrap -> at (799,523) + p_tick: next (0,524); at (799,524) + p_tick: frame_tick = 1, next (0,0).
REQ-036 Assert reset at (700,300) -> next clk: pixel_x = 0, pixel_y = 0, hsync = 1, vsync = 1, no frame_tick; normal timing resumes per REQ-031.
